// File: rtl/timing_sensor_pkg.sv
`default_nettype none
// ============================================================================
// Module  : timing_sensor_pkg
// Brief   : Shared encodings and sensor bit indices for the timing manager
//           and its sensor-side responders.
// Revision: 1.0 - initial release
// ============================================================================
package timing_sensor_pkg;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_SETTLE = 3'd1;
    localparam logic [2:0] c_ST_START  = 3'd2;
    localparam logic [2:0] c_ST_WAIT   = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    localparam int c_DATA_WIDTH_DEF = 16;
    localparam int c_CNT_WIDTH_DEF  = 16;

    // Bit positions inside the timing manager's en_bits / done vectors
    localparam int c_SENSOR_AMDS0   = 0;
    localparam int c_SENSOR_AMDS1   = 1;
    localparam int c_SENSOR_AMDS2   = 2;
    localparam int c_SENSOR_AMDS3   = 3;
    localparam int c_SENSOR_EDDY0   = 4;
    localparam int c_SENSOR_EDDY1   = 5;
    localparam int c_SENSOR_EDDY2   = 6;
    localparam int c_SENSOR_EDDY3   = 7;
    localparam int c_SENSOR_ENCODER = 8;
    localparam int c_SENSOR_ADC     = 9;
    localparam int c_NUM_SENSORS    = 10;

endpackage
`default_nettype wire

// File: rtl/cycle_counter.sv
`default_nettype none
// ============================================================================
// Module  : cycle_counter
// Brief   : Loadable/clearable up-counter with an equality compare.
// Revision: 1.0 - initial release
// ============================================================================
module cycle_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_target,
    output logic             o_match
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_match = (r_count == i_target);

endmodule
`default_nettype wire

// File: rtl/sensor_sync_responder.sv
`default_nettype none
// ============================================================================
// Module  : sensor_sync_responder
// Brief   : Trigger/settle/start/wait sequencer with sample timeout, returning
//           a level done to the timing manager.
// Revision: 1.0 - initial release
// ============================================================================
module sensor_sync_responder
    import timing_sensor_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = c_CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trigger,
    input  logic                  en,
    input  logic [CNT_WIDTH-1:0]  settle_cycles,
    input  logic [CNT_WIDTH-1:0]  timeout_cycles,
    input  logic                  clr_status,
    output logic                  start,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  done,
    output logic                  timeout_err,
    output logic                  busy,
    output logic                  overrun,
    output logic [CNT_WIDTH-1:0]  sample_count,
    output logic [CNT_WIDTH-1:0]  timeout_count
);

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic                  r_start;
    logic                  r_done;
    logic                  r_timeout_err;
    logic                  r_busy;
    logic                  r_overrun;
    logic [DATA_WIDTH-1:0] r_data;
    logic [CNT_WIDTH-1:0]  r_sample_count;
    logic [CNT_WIDTH-1:0]  r_timeout_count;
    logic [CNT_WIDTH-1:0]  r_settle_tgt;
    logic [CNT_WIDTH-1:0]  r_tmo_tgt;
    logic                  r_tmo_en;
    logic                  w_in_busy;
    logic                  w_accept;
    logic                  w_sample_hit;
    logic                  w_timeout_hit;
    logic                  w_settle_match;
    logic                  w_tmo_match;
    logic                  w_next_busy;

    assign w_in_busy   = (r_state == c_ST_SETTLE) || (r_state == c_ST_START) ||
                         (r_state == c_ST_WAIT);
    assign w_accept    = en && trigger && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
    assign w_next_busy = (w_next_state == c_ST_SETTLE) || (w_next_state == c_ST_START) ||
                         (w_next_state == c_ST_WAIT);

    // Targets are stored as N-1 so a counter starting at 0 matches on its Nth cycle
    cycle_counter #(.WIDTH(CNT_WIDTH)) u_settle_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_accept),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_inc      (en && (r_state == c_ST_SETTLE)),
        .i_target   (r_settle_tgt),
        .o_match    (w_settle_match)
    );

    cycle_counter #(.WIDTH(CNT_WIDTH)) u_tmo_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (r_state == c_ST_START),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_inc      (en && (r_state == c_ST_WAIT)),
        .i_target   (r_tmo_tgt),
        .o_match    (w_tmo_match)
    );

    always_comb begin
        w_next_state  = r_state;
        w_sample_hit  = 1'b0;
        w_timeout_hit = 1'b0;
        if (!en) begin
            w_next_state = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (trigger) begin
                        w_next_state = (settle_cycles == '0) ? c_ST_START : c_ST_SETTLE;
                    end
                end
                c_ST_SETTLE: begin
                    if (w_settle_match) w_next_state = c_ST_START;
                end
                c_ST_START: w_next_state = c_ST_WAIT;
                c_ST_WAIT: begin
                    // A sample landing on the expiry cycle still counts as good
                    if (sample_valid) begin
                        w_next_state = c_ST_DONE;
                        w_sample_hit = 1'b1;
                    end else if (r_tmo_en && w_tmo_match) begin
                        w_next_state  = c_ST_DONE;
                        w_timeout_hit = 1'b1;
                    end
                end
                default: w_next_state = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= c_ST_IDLE;
            r_start         <= 1'b0;
            r_done          <= 1'b0;
            r_timeout_err   <= 1'b0;
            r_busy          <= 1'b0;
            r_overrun       <= 1'b0;
            r_data          <= '0;
            r_sample_count  <= '0;
            r_timeout_count <= '0;
            r_settle_tgt    <= '0;
            r_tmo_tgt       <= '0;
            r_tmo_en        <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_start <= (w_next_state == c_ST_START);
            r_done  <= (w_next_state == c_ST_DONE);
            r_busy  <= w_next_busy;

            if (w_next_state != c_ST_DONE) begin
                r_timeout_err <= 1'b0;
            end else if (w_timeout_hit) begin
                r_timeout_err <= 1'b1;
            end

            if (w_accept) begin
                r_settle_tgt <= settle_cycles - CNT_WIDTH'(1);
                r_tmo_tgt    <= timeout_cycles - CNT_WIDTH'(1);
                r_tmo_en     <= (timeout_cycles != '0);
            end

            if (w_sample_hit) r_data <= sample_data;

            if (clr_status) begin
                r_sample_count <= w_sample_hit ? CNT_WIDTH'(1) : '0;
            end else if (w_sample_hit) begin
                r_sample_count <= r_sample_count + CNT_WIDTH'(1);
            end

            if (clr_status) begin
                r_timeout_count <= w_timeout_hit ? CNT_WIDTH'(1) : '0;
            end else if (w_timeout_hit) begin
                r_timeout_count <= r_timeout_count + CNT_WIDTH'(1);
            end

            if (en && trigger && w_in_busy) begin
                r_overrun <= 1'b1;
            end else if (clr_status) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign start         = r_start;
    assign done          = r_done;
    assign timeout_err   = r_timeout_err;
    assign busy          = r_busy;
    assign overrun       = r_overrun;
    assign data_out      = r_data;
    assign sample_count  = r_sample_count;
    assign timeout_count = r_timeout_count;

endmodule
`default_nettype wire

// File: tb/tb_sensor_sync_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_sensor_sync_responder
// Brief   : Directed self-checking bench for sensor_sync_responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sensor_sync_responder;

    localparam int c_DW = 16;
    localparam int c_CW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            trigger;
    logic            en;
    logic [c_CW-1:0] settle_cycles;
    logic [c_CW-1:0] timeout_cycles;
    logic            clr_status;
    logic            start;
    logic            sample_valid;
    logic [c_DW-1:0] sample_data;
    logic [c_DW-1:0] data_out;
    logic            done;
    logic            timeout_err;
    logic            busy;
    logic            overrun;
    logic [c_CW-1:0] sample_count;
    logic [c_CW-1:0] timeout_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_starts = 0;

    sensor_sync_responder #(.DATA_WIDTH(c_DW), .CNT_WIDTH(c_CW)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .trigger        (trigger),
        .en             (en),
        .settle_cycles  (settle_cycles),
        .timeout_cycles (timeout_cycles),
        .clr_status     (clr_status),
        .start          (start),
        .sample_valid   (sample_valid),
        .sample_data    (sample_data),
        .data_out       (data_out),
        .done           (done),
        .timeout_err    (timeout_err),
        .busy           (busy),
        .overrun        (overrun),
        .sample_count   (sample_count),
        .timeout_count  (timeout_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (start) n_starts++;
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; trigger = 1'b0; en = 1'b0; clr_status = 1'b0;
        sample_valid = 1'b0; sample_data = '0; settle_cycles = '0; timeout_cycles = '0;
        tick(); tick();
        n_checks++; if ({start, done, timeout_err, busy, overrun} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {start, done, timeout_err, busy, overrun}); else n_pass++;
        n_checks++; if (data_out !== 16'h0) $display("FAIL reset_data: got %h want 0000", data_out); else n_pass++;
        n_checks++; if (sample_count !== 16'd0 || timeout_count !== 16'd0) $display("FAIL reset_counts: got %0d/%0d want 0/0", sample_count, timeout_count); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_normal();
        en = 1'b1; settle_cycles = 16'd3; timeout_cycles = 16'd100;
        repeat (2) tick();
        n_starts = 0;
        pulse_trigger();
        n_checks++; if (busy !== 1'b1 || start !== 1'b0) $display("FAIL normal_busy: got busy=%b start=%b want 1 0", busy, start); else n_pass++;
        repeat (2) tick();
        n_checks++; if (start !== 1'b0) $display("FAIL normal_early_start: got %b want 0", start); else n_pass++;
        tick();
        n_checks++; if (start !== 1'b1) $display("FAIL normal_start: got %b want 1", start); else n_pass++;
        repeat (5) tick();
        n_checks++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL normal_wait: got done=%b busy=%b want 0 1", done, busy); else n_pass++;
        sample_valid = 1'b1; sample_data = 16'hBEEF;
        tick();
        sample_valid = 1'b0; sample_data = '0;
        n_checks++; if (done !== 1'b1 || busy !== 1'b0 || timeout_err !== 1'b0) $display("FAIL normal_done: got done=%b busy=%b terr=%b want 1 0 0", done, busy, timeout_err); else n_pass++;
        n_checks++; if (data_out !== 16'hBEEF) $display("FAIL normal_data: got %h want beef", data_out); else n_pass++;
        n_checks++; if (sample_count !== 16'd1 || n_starts != 1) $display("FAIL normal_counts: got samples=%0d starts=%0d want 1 1", sample_count, n_starts); else n_pass++;
    endtask

    task automatic test_timeout();
        settle_cycles = 16'd2; timeout_cycles = 16'd8;
        pulse_trigger();
        n_checks++; if (done !== 1'b0) $display("FAIL timeout_done_drop: got %b want 0", done); else n_pass++;
        repeat (2) tick();
        n_checks++; if (start !== 1'b1) $display("FAIL timeout_start: got %b want 1", start); else n_pass++;
        repeat (8) tick();
        n_checks++; if (done !== 1'b0) $display("FAIL timeout_early: got %b want 0", done); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b1 || timeout_err !== 1'b1) $display("FAIL timeout_done: got done=%b terr=%b want 1 1", done, timeout_err); else n_pass++;
        n_checks++; if (timeout_count !== 16'd1 || sample_count !== 16'd1) $display("FAIL timeout_counts: got tmo=%0d samples=%0d want 1 1", timeout_count, sample_count); else n_pass++;
        n_checks++; if (data_out !== 16'hBEEF) $display("FAIL timeout_data: got %h want beef", data_out); else n_pass++;
    endtask

    task automatic test_valid_in_start();
        settle_cycles = 16'd1; timeout_cycles = 16'd100;
        pulse_trigger();
        n_checks++; if (done !== 1'b0 || timeout_err !== 1'b0) $display("FAIL retrig_drop: got done=%b terr=%b want 0 0", done, timeout_err); else n_pass++;
        tick();
        n_checks++; if (start !== 1'b1) $display("FAIL vstart_start: got %b want 1", start); else n_pass++;
        sample_valid = 1'b1; sample_data = 16'h1111;
        tick();
        sample_valid = 1'b0;
        n_checks++; if (done !== 1'b0 || busy !== 1'b1 || data_out !== 16'hBEEF) $display("FAIL vstart_ignored: got done=%b busy=%b data=%h want 0 1 beef", done, busy, data_out); else n_pass++;
        sample_valid = 1'b1; sample_data = 16'h2222;
        tick();
        sample_valid = 1'b0;
        n_checks++; if (done !== 1'b1 || data_out !== 16'h2222 || sample_count !== 16'd2) $display("FAIL vstart_sample: got done=%b data=%h samples=%0d want 1 2222 2", done, data_out, sample_count); else n_pass++;
    endtask

    task automatic test_overrun();
        settle_cycles = 16'd5; timeout_cycles = 16'd0;
        n_starts = 0;
        pulse_trigger();
        pulse_trigger();
        n_checks++; if (overrun !== 1'b1 || busy !== 1'b1) $display("FAIL overrun_set: got ovr=%b busy=%b want 1 1", overrun, busy); else n_pass++;
        repeat (3) tick();
        n_checks++; if (start !== 1'b0) $display("FAIL overrun_early_start: got %b want 0", start); else n_pass++;
        tick();
        n_checks++; if (start !== 1'b1) $display("FAIL overrun_start: got %b want 1", start); else n_pass++;
        repeat (12) tick();
        n_checks++; if (done !== 1'b0 || busy !== 1'b1 || n_starts != 1) $display("FAIL overrun_wait: got done=%b busy=%b starts=%0d want 0 1 1", done, busy, n_starts); else n_pass++;
        sample_valid = 1'b1; sample_data = 16'hCAFE;
        tick();
        sample_valid = 1'b0;
        n_checks++; if (done !== 1'b1 || data_out !== 16'hCAFE || sample_count !== 16'd3 || overrun !== 1'b1) $display("FAIL overrun_sample: got done=%b data=%h samples=%0d ovr=%b want 1 cafe 3 1", done, data_out, sample_count, overrun); else n_pass++;
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        n_checks++; if (overrun !== 1'b0 || sample_count !== 16'd0 || timeout_count !== 16'd0 || done !== 1'b1) $display("FAIL clear_status: got ovr=%b samples=%0d tmo=%0d done=%b want 0 0 0 1", overrun, sample_count, timeout_count, done); else n_pass++;
    endtask

    task automatic test_settle_zero_tie();
        settle_cycles = 16'd0; timeout_cycles = 16'd4;
        pulse_trigger();
        n_checks++; if (start !== 1'b1) $display("FAIL settle0_start: got %b want 1", start); else n_pass++;
        repeat (4) tick();
        n_checks++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL tie_wait: got done=%b busy=%b want 0 1", done, busy); else n_pass++;
        sample_valid = 1'b1; sample_data = 16'h5A5A; clr_status = 1'b1;
        tick();
        sample_valid = 1'b0; clr_status = 1'b0;
        n_checks++; if (done !== 1'b1 || timeout_err !== 1'b0 || data_out !== 16'h5A5A) $display("FAIL tie_done: got done=%b terr=%b data=%h want 1 0 5a5a", done, timeout_err, data_out); else n_pass++;
        n_checks++; if (sample_count !== 16'd1 || timeout_count !== 16'd0) $display("FAIL tie_counts: got samples=%0d tmo=%0d want 1 0", sample_count, timeout_count); else n_pass++;
    endtask

    task automatic test_en_abort();
        settle_cycles = 16'd1; timeout_cycles = 16'd50;
        pulse_trigger();
        tick();
        n_checks++; if (start !== 1'b1) $display("FAIL abort_start: got %b want 1", start); else n_pass++;
        repeat (2) tick();
        en = 1'b0;
        tick();
        n_checks++; if ({busy, done, start, timeout_err} !== 4'b0) $display("FAIL abort_idle: got %b want 0000", {busy, done, start, timeout_err}); else n_pass++;
        n_checks++; if (sample_count !== 16'd1 || timeout_count !== 16'd0 || data_out !== 16'h5A5A) $display("FAIL abort_counts: got samples=%0d tmo=%0d data=%h want 1 0 5a5a", sample_count, timeout_count, data_out); else n_pass++;
        pulse_trigger();
        n_checks++; if (busy !== 1'b0) $display("FAIL en0_trigger: got busy=%b want 0", busy); else n_pass++;
        en = 1'b1; sample_valid = 1'b1; sample_data = 16'h7777;
        tick();
        sample_valid = 1'b0;
        n_checks++; if (done !== 1'b0 || sample_count !== 16'd1 || data_out !== 16'h5A5A) $display("FAIL idle_valid: got done=%b samples=%0d data=%h want 0 1 5a5a", done, sample_count, data_out); else n_pass++;
    endtask

    task automatic test_reset_abort();
        settle_cycles = 16'd4; timeout_cycles = 16'd10;
        pulse_trigger();
        tick();
        n_checks++; if (busy !== 1'b1) $display("FAIL rabort_busy: got %b want 1", busy); else n_pass++;
        rst_n = 1'b0;
        tick();
        n_checks++; if ({start, done, timeout_err, busy, overrun} !== 5'b0 || data_out !== 16'h0) $display("FAIL rabort_outputs: got %b data=%h want 00000 0000", {start, done, timeout_err, busy, overrun}, data_out); else n_pass++;
        n_checks++; if (sample_count !== 16'd0 || timeout_count !== 16'd0) $display("FAIL rabort_counts: got %0d/%0d want 0/0", sample_count, timeout_count); else n_pass++;
        rst_n = 1'b1;
        tick();
        settle_cycles = 16'd2;
        n_starts = 0;
        pulse_trigger();
        repeat (2) tick();
        n_checks++; if (start !== 1'b1) $display("FAIL post_reset_start: got %b want 1", start); else n_pass++;
        tick();
        sample_valid = 1'b1; sample_data = 16'h0F0F;
        tick();
        sample_valid = 1'b0;
        n_checks++; if (done !== 1'b1 || data_out !== 16'h0F0F || sample_count !== 16'd1 || n_starts != 1) $display("FAIL post_reset_acq: got done=%b data=%h samples=%0d starts=%0d want 1 0f0f 1 1", done, data_out, sample_count, n_starts); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_normal();
        test_timeout();
        test_valid_in_start();
        test_overrun();
        test_settle_zero_tie();
        test_en_abort();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sensor_sync_responder.md
# sensor_sync_responder

Sensor-side counterpart of the timing manager's trigger/enable/done protocol. One instance sits beside each sensor acquisition engine (ADC, encoder, AMDS, eddy current). It accepts the timing manager's trigger pulse and enable bit, sequences a settle delay and a start strobe into the engine, and waits for the sample with a timeout. It then presents a level `done` back to the timing manager, so `all_done` can never hang on a dead sensor.

## Interface
Parameters:
- `DATA_WIDTH`, 16: width of sample data.
- `CNT_WIDTH`, 16: width of the settle, timeout and statistics counters.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `trigger`  in  1  one-cycle pulse from the timing manager.
- `en`  in  1  sensor enable bit (`en_bits[n]`) from the timing manager.
- `settle_cycles`  in  CNT_WIDTH  delay from trigger to start strobe.
- `timeout_cycles`  in  CNT_WIDTH  maximum wait for a sample; 0 disables the timeout.
- `clr_status`  in  1  clears `overrun` and both statistics counters.
- `start`  out  1  one-cycle start strobe to the acquisition engine.
- `sample_valid`  in  1  engine's sample strobe.
- `sample_data`  in  DATA_WIDTH  engine's sample; qualified by `sample_valid`.
- `data_out`  out  DATA_WIDTH  last good sample.
- `done`  out  1  level; acquisition complete. Drives the timing manager's `*_done` input.
- `timeout_err`  out  1  the current `done` was caused by a timeout.
- `busy`  out  1  state is SETTLE, START or WAIT.
- `overrun`  out  1  sticky; a trigger arrived while `busy`.
- `sample_count`  out  CNT_WIDTH  good samples since reset or clear; wraps.
- `timeout_count`  out  CNT_WIDTH  timeouts since reset or clear; wraps.

## Operation
States are IDLE, SETTLE, START, WAIT and DONE.

- **IDLE:** a `trigger` with `en`=1 goes to SETTLE, or directly to START if `settle_cycles`=0. A trigger with `en`=0 is ignored.
- **SETTLE:** counts up from 0. Goes to START when the count reaches `settle_cycles`−1. `settle_cycles` is sampled at trigger time.
- **START:** `start`=1 for exactly this cycle, then go to WAIT. The timeout counter is cleared.
- **WAIT:**
  - On `sample_valid`=1: latch `sample_data` into `data_out`, increment `sample_count`, go to DONE with `timeout_err`=0.
  - Otherwise the counter increments. When the counter equals `timeout_cycles` (which must be nonzero): increment `timeout_count`, go to DONE with `timeout_err`=1. `data_out` is unchanged.
- **DONE:** `done`=1 and held. A new `trigger` with `en`=1 starts the next acquisition exactly as from IDLE; `done` and `timeout_err` drop on the next cycle.
- **`en` low:** in any state, `en`=0 forces IDLE on the next cycle. `done`, `start` and `timeout_err` go to 0 and no counter changes.
- **`sample_valid` outside WAIT:** ignored, including during the START cycle.
- **Trigger while busy:** the trigger is ignored and `overrun` is set; the acquisition continues.
- **`clr_status`:** set wins over clear when both occur in the same cycle; for the counters, an increment in the same cycle as a clear leaves the counter at 1.
- **Sample and timeout together:** `sample_valid` wins over timeout expiry in the same cycle.

## Timing
- **Reset:** `rst_n` is sampled low at a clock edge. After that edge every output is 0 and the state is IDLE, including when reset arrives mid-acquisition.
- **Output registers:** all outputs are registered. There is no combinational path from input to output.
- **Trigger to start:** trigger sampled at cycle 0 gives `start`=1 in cycle 1+`settle_cycles`.
- **Sample to done:** `sample_valid` sampled at cycle k in WAIT gives `done`=1 and the new `data_out` at cycle k+1, in the same cycle.
- **Timeout to done:** with timeout T, `done`=1 and `timeout_err`=1 appear T+1 cycles after the `start` cycle.
- **Done drop:** `done` falls one cycle after an accepted trigger. This gives the timing manager a fresh rising edge for its done-edge detection.
- **Busy:** high from the cycle after the trigger through the last WAIT cycle.

## Structure
- **Shared package:** `timing_sensor_pkg` holds:
  - state encoding localparams (IDLE=0, SETTLE=1, START=2, WAIT=3, DONE=4, 3-bit);
  - default `DATA_WIDTH` and `CNT_WIDTH`;
  - the sensor bit-index constants (AMDS 0–3 = bits 0–3, eddy 0–3 = bits 4–7, encoder = 8, ADC = 9), shared with the timing manager.
- **Sub-module:** `cycle_counter` is a loadable/clearable up-counter with an equality compare. It is instantiated twice, for settle and for timeout.
- **Top level:** FSM, data latch, statistics counters and overrun flag.

## Test plan
- **Normal acquisition:** reset, `en`=1, `settle_cycles`=3, `timeout_cycles`=100; trigger at cycle 10, `sample_valid` with 0xBEEF 5 cycles after `start` → `start` at cycle 14, `done`=1 and `data_out`=0xBEEF at cycle 20, `sample_count`=1, `timeout_err`=0.
- **Timeout:** `timeout_cycles`=8, no `sample_valid` → `done`=1, `timeout_err`=1 nine cycles after `start`, `timeout_count`=1, `data_out` unchanged. Next trigger clears `done` one cycle later.
- **Overrun:** second trigger during SETTLE → `overrun`=1, single `start`. Then `clr_status`=1 → `overrun`, `sample_count` and `timeout_count` all 0.
- **Boundaries:**
  - `settle_cycles`=0 → `start` in the cycle after the trigger.
  - `sample_valid` during START → ignored.
  - Valid and timeout expiry in the same cycle (`timeout_cycles`=4, valid on the 4th WAIT cycle) → `timeout_err`=0, sample latched.
- **Enable/reset abort:** `en`→0 during WAIT → IDLE next cycle, `done`=0, no counter change. `rst_n`=0 during SETTLE → all outputs 0 after the edge; a later trigger performs a normal acquisition.
